// File: rtl/add32_if.sv
// Operand/result bundle for the add32 datapath unit.
// master drives operands and consumes results; slave is the adder side.
interface add32_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] answer;
    logic             carry;
    logic             out_valid;

    modport master (output in_valid, a, b, input answer, carry, out_valid);
    modport slave  (input in_valid, a, b, output answer, carry, out_valid);
endinterface

// File: rtl/add32.sv
// Two-level carry-lookahead unsigned adder with a single registered output stage.
// 4-bit CLA groups feed a flat sum-of-products lookahead across the groups.
module cla4 (
    input  logic [3:0] g_i,
    input  logic [3:0] p_i,
    input  logic       c_i,
    output logic [3:0] c_o,
    output logic       gg_o,
    output logic       gp_o
);
    // c_o[n] is the carry into bit n of the group
    assign c_o[0] = c_i;
    assign c_o[1] = g_i[0] | (p_i[0] & c_i);
    assign c_o[2] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & c_i);
    assign c_o[3] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
                  | (p_i[2] & p_i[1] & p_i[0] & c_i);
    assign gg_o   = g_i[3] | (p_i[3] & g_i[2]) | (p_i[3] & p_i[2] & g_i[1])
                  | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);
    assign gp_o   = &p_i;
endmodule

module add32 #(
    parameter int WIDTH = 32
) (
    input  logic   clk,
    input  logic   rst_n,
    add32_if.slave bus
);
    localparam int NG = WIDTH / 4;

    logic [WIDTH-1:0] g, p, c;
    logic [NG-1:0]    grp_g, grp_p;
    logic [NG:0]      grp_c;
    logic [WIDTH-1:0] answer_q, answer_d;
    logic             carry_q, carry_d;
    logic             out_valid_q;

    // Carry into group k as a flat OR of generate terms, each gated by the
    // propagates of the groups between it and k; no carry-in exists.
    function automatic logic lookahead(input logic [NG-1:0] gg,
                                       input logic [NG-1:0] gp,
                                       input int k);
        logic acc;
        logic term;
        acc = 1'b0;
        for (int j = 0; j < NG; j++) begin
            if (j < k) begin
                term = gg[j];
                for (int m = 0; m < NG; m++)
                    if (m > j && m < k) term = term & gp[m];
                acc = acc | term;
            end
        end
        return acc;
    endfunction

    assign g = bus.a & bus.b;
    assign p = bus.a ^ bus.b;

    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        cla4 u_cla (
            .g_i  (g[4*gi +: 4]),
            .p_i  (p[4*gi +: 4]),
            .c_i  (grp_c[gi]),
            .c_o  (c[4*gi +: 4]),
            .gg_o (grp_g[gi]),
            .gp_o (grp_p[gi])
        );
    end

    for (genvar k = 0; k <= NG; k++) begin : g_look
        assign grp_c[k] = lookahead(grp_g, grp_p, k);
    end

    assign answer_d = p ^ c;
    assign carry_d  = grp_c[NG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            answer_q    <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                answer_q <= answer_d;
                carry_q  <= carry_d;
            end
        end
    end

    assign bus.answer    = answer_q;
    assign bus.carry     = carry_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_add32.sv
// Randomised and directed checks of add32 against a 33-bit arithmetic reference.
module tb_add32;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    logic [32:0] held;   // last loaded {carry, answer}

    add32_if #(.WIDTH(32)) bus ();
    add32 #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    function automatic logic [32:0] ref_sum(input logic [31:0] x, input logic [31:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    // Present operands for one edge, then look just after that edge.
    task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        bus.in_valid = v; bus.a = x; bus.b = y;
        @(posedge clk);
        #1;
        if (v) held = ref_sum(x, y);
    endtask

    task automatic test_reset;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0;
        rst_n = 1'b0;
        #3;
        vectors++;
        if ({bus.carry, bus.answer} !== 33'd0 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async: got c=%b ans=%h v=%b, want 0/0/0", bus.carry, bus.answer, bus.out_valid);
        end
        @(negedge clk); rst_n = 1'b1;
        held = 33'd0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'd0, 32'd0);
            vectors++;
            if (bus.out_valid !== 1'b0 || {bus.carry, bus.answer} !== 33'd0) begin
                miscompares++;
                $display("FAIL reset_idle%0d: got v=%b sum=%h, want v=0 sum=0", i, bus.out_valid, {bus.carry, bus.answer});
            end
        end
    endtask

    task automatic test_basic;
        drive(1'b1, 32'd5, 32'd7);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.answer !== 32'd12 || bus.carry !== 1'b0) begin
            miscompares++;
            $display("FAIL basic: got v=%b c=%b ans=%h, want 1/0/0000000c", bus.out_valid, bus.carry, bus.answer);
        end
        drive(1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.answer !== 32'd12 || bus.carry !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_hold: got v=%b c=%b ans=%h, want 0/0/0000000c", bus.out_valid, bus.carry, bus.answer);
        end
    endtask

    task automatic test_boundaries;
        logic [31:0] ta [7] = '{32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_000F,
                                32'h0FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [31:0] tb [7] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h1,
                                32'h1, 32'h8000_0000, 32'h8000_0001};
        logic [32:0] want [7] = '{33'h0_0000_0000, 33'h1_0000_0000, 33'h1_FFFF_FFFE,
                                  33'h0_0000_0010, 33'h0_1000_0000, 33'h1_0000_0000,
                                  33'h1_0000_0000};
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, ta[i], tb[i]);
            vectors++;
            if ({bus.carry, bus.answer} !== want[i] || bus.out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL boundary%0d: %h+%h got v=%b sum=%h, want v=1 sum=%h",
                         i, ta[i], tb[i], bus.out_valid, {bus.carry, bus.answer}, want[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [32:0] q [$];
        logic [31:0] x, y;
        logic [32:0] exp;
        for (int i = 0; i < 100; i++) begin
            x = $urandom; y = $urandom;
            if (i % 10 == 0) y = ~x + 32'(i % 3);   // steer toward long carry chains
            q.push_back(ref_sum(x, y));
            drive(1'b1, x, y);
            exp = q.pop_front();
            vectors++;
            if ({bus.carry, bus.answer} !== exp || bus.out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL stream%0d: got v=%b sum=%h, want v=1 sum=%h", i, bus.out_valid, {bus.carry, bus.answer}, exp);
            end
        end
    endtask

    task automatic test_reset_midstream;
        logic [31:0] x, y;
        for (int i = 0; i < 5; i++) drive(1'b1, $urandom, $urandom);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.carry, bus.answer} !== 33'd0 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_clear: got v=%b sum=%h, want 0/0", bus.out_valid, {bus.carry, bus.answer});
        end
        @(posedge clk); #1;
        vectors++;
        if ({bus.carry, bus.answer} !== 33'd0 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_held: got v=%b sum=%h, want 0/0", bus.out_valid, {bus.carry, bus.answer});
        end
        @(negedge clk);
        rst_n = 1'b1;
        x = $urandom; y = $urandom;
        bus.in_valid = 1'b1; bus.a = x; bus.b = y;
        @(posedge clk); #1;
        vectors++;
        if ({bus.carry, bus.answer} !== ref_sum(x, y) || bus.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_first: got v=%b sum=%h, want v=1 sum=%h", bus.out_valid, {bus.carry, bus.answer}, ref_sum(x, y));
        end
        drive(1'b0, 32'd0, 32'd0);
        vectors++;
        if (bus.out_valid !== 1'b0 || {bus.carry, bus.answer} !== ref_sum(x, y)) begin
            miscompares++;
            $display("FAIL midreset_idle: got v=%b sum=%h, want v=0 sum=%h", bus.out_valid, {bus.carry, bus.answer}, ref_sum(x, y));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_back_to_back();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/add32.md
Name: add32

Overview:
- 32-bit unsigned adder with carry-out, built as a two-level carry-lookahead adder.
- Inputs are registered into the output stage after the adder; results appear one clock after they are presented.
- Serves as the ADD datapath unit of the toy ALU.
- Covers the full operand range, including wrap-around modulo 2^32 with the overflow bit reported on carry.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of 4. 32 is the only verified configuration.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands on a/b are valid this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- answer  output  WIDTH  registered sum bits [WIDTH-1:0] of a+b.
- carry  output  1  registered carry-out (bit WIDTH of a+b).
- out_valid  output  1  answer/carry hold a result produced by an in_valid cycle.

Behaviour:
- Interface: one clock domain; reset is asynchronous and active-low. While rst_n=0, answer=0, carry=0 and out_valid=0 immediately, independent of clk.
- Arithmetic: {carry, answer} = a + b as a zero-extended (WIDTH+1)-bit unsigned sum. There is no carry-in and no signed overflow flag.
- Adder structure:
  - Per bit: generate g=a&b, propagate p=a^b.
  - 4-bit CLA blocks compute internal carries and group G/P.
  - A second-level lookahead unit over the WIDTH/4 groups computes group carry-ins.
  - sum = p ^ c.
  - A ripple-carry chain is not acceptable.
  - The result must equal a+b bit-exactly for all inputs.
- Latency: exactly 1 cycle.
  - On a rising clk edge with in_valid=1: answer and carry load the sum of the a/b sampled at that edge, and out_valid<=1.
  - On an edge with in_valid=0: out_valid<=0, and answer/carry hold their previous values.
- Throughput: one operation per cycle, with back-to-back in_valid accepted. There is no backpressure and no ready signal.
- Boundaries:
  - a=b=0 gives 0, carry 0.
  - 0xFFFFFFFF+1 gives answer 0, carry 1 (full carry propagate across every group).
  - 0xFFFFFFFF+0xFFFFFFFF gives 0xFFFFFFFE, carry 1.
  - 0x80000000+0x80000000 gives 0, carry 1.
- Reset mid-operation: an in-flight result is discarded; out_valid=0 after reset. The first valid result after rst_n deasserts appears one edge after the first in_valid edge.
- Outputs are driven only from flops; there is no combinational path from inputs to outputs.

Test Plan:
- Reset: assert rst_n=0 asynchronously between edges -> answer=0, carry=0, out_valid=0 immediately. Release, with in_valid=0 for 2 cycles -> out_valid stays 0.
- Basic: a=5, b=7, in_valid=1 for one cycle -> next edge answer=12, carry=0, out_valid=1. The following cycle out_valid=0 and answer stays 12.
- Carry chain: a=0xFFFFFFFF, b=1 -> answer=0x00000000, carry=1. Also a=0xFFFFFFFF, b=0xFFFFFFFF -> answer=0xFFFFFFFE, carry=1.
- Group boundaries: a=0x0000000F, b=1 -> 0x10. a=0x0FFFFFFF, b=1 -> 0x10000000, carry 0. a=0x80000000, b=0x80000000 -> 0, carry 1.
- Streaming: 100 consecutive cycles of random a/b with in_valid=1 -> each cycle's {carry, answer} equals the 33-bit reference sum of the previous cycle's operands, with no bubbles.
- Reset mid-stream: drop rst_n during streaming -> outputs clear at once. After release, the first valid result matches the first post-reset operands.
